uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter that serialises a parallel word onto a single line: one start bit (0), BIT_NUM data bits MSB first, and one stop bit (1), with every bit exactly CLK_CYCLES clocks wide. It is the transmit-side counterpart of the team's uart_rx, which fills its output register MSB-first, so the two connect back-to-back in loopback. A one-deep holding register behind a valid/ready handshake allows frames to be sent back-to-back with no idle gap.

Parameters:
CLK_CYCLES, 868, clocks per bit (clk_freq / baud = 100_000_000 / 115200); legal range 2..65535.
BIT_NUM, 8, data bits per frame; legal range 1..15.

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_tx_data  input  BIT_NUM  word to transmit; sampled only on acceptance
i_tx_valid  input  1  sender has a word; must stay high until accepted
o_tx_ready  output  1  holding register empty; a word is accepted on a cycle where valid && ready
o_tx_serial  output  1  serial line, registered, idles high
o_tx_busy  output  1  high while any start, data or stop bit is on the line
o_tx_done  output  1  one-cycle pulse on the clock that ends a stop bit

Behaviour:
- Reset (i_rst_n=0, acts asynchronously): o_tx_serial=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0. State is IDLE, bit counter and bit index are 0, holding register is empty.
- Reset asserted mid-frame: the line returns high at once. The current frame and any held word are discarded. There is no partial-frame recovery.
- Acceptance: on an edge where i_tx_valid && o_tx_ready, i_tx_data is loaded into the holding register and o_tx_ready drops on that edge.
  - o_tx_ready rises again on the edge after the holding register transfers to the shift register.
  - Valid while not ready is ignored. The bench holds the data; nothing is lost.
- States (2-bit): IDLE, START, DATA, STOP.
- IDLE: o_tx_serial=1. If the holding register is full, on the next edge:
  - load the shift register and free the holding register;
  - go to START, with o_tx_serial=0 and o_tx_busy=1.
  - Latency: the start bit begins one clock after acceptance.
- START: the line is held at 0 for CLK_CYCLES clocks (counter runs 0..CLK_CYCLES-1), then go to DATA with the MSB on the line.
- DATA: each bit is held CLK_CYCLES clocks, bit order MSB down to LSB. After the last bit (index BIT_NUM-1) go to STOP with o_tx_serial=1.
- STOP: the line is held at 1 for a full CLK_CYCLES clocks. On the final edge of STOP, o_tx_done pulses high for one cycle, then:
  - if the holding register is full, go directly to START and load the shift register (back-to-back, zero idle clocks); o_tx_busy stays 1;
  - otherwise go to IDLE and set o_tx_busy=0.
- Frame length: exactly (BIT_NUM+2)*CLK_CYCLES clocks.
- Counter is 16 bits and cleared at every bit boundary. There is no wrap for legal CLK_CYCLES values.
- Simultaneous events:
  - acceptance during any state of an active frame is legal (ready is high as soon as the holding register has emptied);
  - acceptance on the same edge that STOP completes is seen next cycle (IDLE then START, one idle clock).
- o_tx_serial comes straight from a flop, so the line is glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3 (shared with uart_rx);
  - counter width constant 16;
  - default CLK_CYCLES=868 and BIT_NUM=8.
- One natural sub-module, uart_bit_timer: a 16-bit counter with a restart input that emits a one-cycle tick every CLK_CYCLES clocks. It is reusable by uart_rx.

Test Plan:
- Reset release: hold i_tx_valid=0 for 20 clocks -> o_tx_serial=1, o_tx_ready=1, o_tx_busy=0, o_tx_done never pulses.
- Single frame, CLK_CYCLES=4, BIT_NUM=8, send 0xA5 accepted at edge k:
  - o_tx_serial=0 for clocks k+1..k+4;
  - then bits 1,0,1,0,0,1,0,1, each 4 clocks;
  - stop bit =1 for 4 clocks;
  - o_tx_done pulses once at edge k+40; o_tx_busy drops after.
- Back-to-back: send 0xFF, then offer 0x00 during the first frame's DATA state -> the 0x00 start bit begins the clock after the 0xFF stop bit ends, with no idle high clock. Exactly two done pulses, 40 clocks apart.
- Loopback to uart_rx (CLK_CYCLES=868, BIT_NUM=8): send 0x3C then 0xC3 -> uart_rx o_rx_data equals 0x3C, then 0xC3, after each stop bit.
- Reset mid-DATA with a word held: assert i_rst_n=0 -> o_tx_serial=1 immediately, o_tx_ready=1, o_tx_busy=0. A subsequent 0x5A transmits as a correct, complete frame.
- Data stability: raise i_tx_valid while o_tx_ready=0, change i_tx_data from 0x11 to 0x22 before acceptance -> only 0x22 (the value at acceptance) is transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART state encoding, counter width and defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int c_CNT_W          = 16;
    localparam int c_IDX_W          = 4;
    localparam int c_DEF_CLK_CYCLES = 868;
    localparam int c_DEF_BIT_NUM    = 8;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Free-running bit-period counter; one-cycle tick every
//                CLK_CYCLES clocks, held at zero while restart is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_CYCLES = c_DEF_CLK_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    assign o_tick = (r_count == c_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_restart || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter, MSB first, 1 start / 1 stop bit, with a
//                one-deep holding register for back-to-back frames.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_CYCLES = c_DEF_CLK_CYCLES,
    parameter int BIT_NUM    = c_DEF_BIT_NUM
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [BIT_NUM-1:0] i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    output logic               o_tx_serial,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BIT_NUM - 1);

    uart_state_e        r_state, w_state_nxt;
    logic [BIT_NUM-1:0] r_hold;
    logic               r_hold_full;
    logic [BIT_NUM-1:0] r_shift, w_shift_nxt, w_shl;
    logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
    logic               r_serial, w_serial_nxt;
    logic               w_load;
    logic               w_accept;
    logic               w_tick;

    uart_bit_timer #(
        .CLK_CYCLES (CLK_CYCLES)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (r_state == IDLE),
        .o_tick    (w_tick)
    );

    assign w_accept    = i_tx_valid && !r_hold_full;
    assign w_shl       = r_shift << 1;
    assign o_tx_ready  = !r_hold_full;
    assign o_tx_serial = r_serial;
    assign o_tx_busy   = (r_state != IDLE);
    assign o_tx_done   = (r_state == STOP) && w_tick;

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_serial_nxt = r_serial;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_serial_nxt = 1'b1;
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_nxt  = START;
                    w_serial_nxt = 1'b0;
                    w_shift_nxt  = r_hold;
                    w_idx_nxt    = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt  = DATA;
                    w_serial_nxt = r_shift[BIT_NUM-1];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt  = STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_idx_nxt    = r_idx + c_IDX_W'(1);
                        w_shift_nxt  = w_shl;
                        w_serial_nxt = w_shl[BIT_NUM-1];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    // Pending word chains straight into the next start bit.
                    if (r_hold_full) begin
                        w_load       = 1'b1;
                        w_state_nxt  = START;
                        w_serial_nxt = 1'b0;
                        w_shift_nxt  = r_hold;
                        w_idx_nxt    = '0;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_serial_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_serial_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_serial <= w_serial_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule

`default_nettype wire
